// File: rtl/vanilla_interrupt_ctrl_if.sv
// Signal bundle between the CSR file / pipeline and the interrupt-entry sequencer.
// The master side drives pending/enable/pipeline status; the slave (controller) drives entry outputs.
interface vanilla_interrupt_ctrl_if #(
    parameter int pc_width_p    = 22,
    parameter int count_width_p = 16
);
    logic                     mstatus_mie_i;
    logic [1:0]               mip_i;
    logic [1:0]               mie_i;
    logic                     safe_point_i;
    logic                     mret_i;
    logic                     interrupt_entered_o;
    logic [pc_width_p-1:0]    interrupt_pc_o;
    logic [1:0]               interrupt_cause_o;
    logic                     in_handler_o;
    logic [count_width_p-1:0] interrupt_count_o;

    modport master (
        output mstatus_mie_i, mip_i, mie_i, safe_point_i, mret_i,
        input  interrupt_entered_o, interrupt_pc_o, interrupt_cause_o,
               in_handler_o, interrupt_count_o
    );

    modport slave (
        input  mstatus_mie_i, mip_i, mie_i, safe_point_i, mret_i,
        output interrupt_entered_o, interrupt_pc_o, interrupt_cause_o,
               in_handler_o, interrupt_count_o
    );
endinterface

// File: rtl/vanilla_interrupt_ctrl.sv
// Interrupt-entry sequencer: prioritises remote over trace, waits for a pipeline safe point,
// pulses entry with the handler PC, and tracks handler occupancy until mret.
module vanilla_interrupt_ctrl #(
    parameter int                    pc_width_p      = 22,
    parameter logic [pc_width_p-1:0] remote_vector_p = 'h1,
    parameter logic [pc_width_p-1:0] trace_vector_p  = 'h2,
    parameter int                    count_width_p   = 16
) (
    input logic                     clk_i,
    input logic                     reset_i,
    vanilla_interrupt_ctrl_if.slave ctrl
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        ENTER,
        HANDLER
    } state_e;

    state_e                   state_q;
    logic [1:0]               cause_q;
    logic                     entered_q;
    logic [pc_width_p-1:0]    pc_q;
    logic                     in_handler_q;
    logic [count_width_p-1:0] count_q;

    logic [1:0] pend;
    logic       take;
    logic [1:0] prio_cause;

    assign pend       = ctrl.mip_i & ctrl.mie_i;
    assign take       = ctrl.mstatus_mie_i & (|pend);
    // Remote (bit 0) always wins; only meaningful when take is true.
    assign prio_cause = pend[0] ? 2'b01 : (pend[1] ? 2'b10 : 2'b00);

    // NOTE: all state here uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= IDLE;
            cause_q      <= 2'b00;
            entered_q    <= 1'b0;
            pc_q         <= '0;
            in_handler_q <= 1'b0;
            count_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        cause_q <= prio_cause;
                        state_q <= ARM;
                    end
                end

                ARM: begin
                    if (!take) begin
                        cause_q <= 2'b00;
                        state_q <= IDLE;
                    end else begin
                        // Re-latching lets a late remote preempt a trace still waiting here.
                        cause_q <= prio_cause;
                        if (ctrl.safe_point_i) begin
                            entered_q <= 1'b1;
                            pc_q      <= prio_cause[0] ? remote_vector_p : trace_vector_p;
                            state_q   <= ENTER;
                        end
                    end
                end

                ENTER: begin
                    entered_q    <= 1'b0;
                    pc_q         <= '0;
                    in_handler_q <= 1'b1;
                    state_q      <= HANDLER;
                    if (!(&count_q)) begin
                        count_q <= count_q + 1'b1;
                    end
                end

                HANDLER: begin
                    // Pending/enable inputs are deliberately ignored: no nesting.
                    if (ctrl.mret_i) begin
                        in_handler_q <= 1'b0;
                        cause_q      <= 2'b00;
                        state_q      <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ctrl.interrupt_entered_o = entered_q;
    assign ctrl.interrupt_pc_o      = pc_q;
    assign ctrl.interrupt_cause_o   = cause_q;
    assign ctrl.in_handler_o        = in_handler_q;
    assign ctrl.interrupt_count_o   = count_q;

endmodule

// File: tb/tb_vanilla_interrupt_ctrl.sv
// Directed bench for vanilla_interrupt_ctrl: a default-width instance for sequencing/priority
// and a 2-bit-counter instance for saturation and asynchronous reset.
module tb_vanilla_interrupt_ctrl;

    localparam int PCW = 22;

    logic clk_i;
    logic reset_i;
    int   checks;
    int   errors;
    int   exp_count;

    vanilla_interrupt_ctrl_if #(.pc_width_p(PCW), .count_width_p(16)) bus ();
    vanilla_interrupt_ctrl_if #(.pc_width_p(PCW), .count_width_p(2))  bus_s ();

    vanilla_interrupt_ctrl #(
        .pc_width_p(PCW), .remote_vector_p(22'h1), .trace_vector_p(22'h2), .count_width_p(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .ctrl(bus)
    );

    vanilla_interrupt_ctrl #(
        .pc_width_p(PCW), .remote_vector_p(22'h1), .trace_vector_p(22'h2), .count_width_p(2)
    ) dut_s (
        .clk_i(clk_i), .reset_i(reset_i), .ctrl(bus_s)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag, input logic ent, input logic [PCW-1:0] pc,
                              input logic [1:0] cause, input logic inh, input int cnt);
        check({tag, ".entered"},    32'(bus.interrupt_entered_o), 32'(ent));
        check({tag, ".pc"},         32'(bus.interrupt_pc_o),      32'(pc));
        check({tag, ".cause"},      32'(bus.interrupt_cause_o),   32'(cause));
        check({tag, ".in_handler"}, 32'(bus.in_handler_o),        32'(inh));
        check({tag, ".count"},      32'(bus.interrupt_count_o),   32'(cnt));
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_s[5] = '{1, 2, 3, 3, 3};
        checks    = 0;
        errors    = 0;
        exp_count = 0;

        reset_i            = 1'b1;
        bus.mstatus_mie_i  = 1'b0; bus.mip_i   = 2'b00; bus.mie_i   = 2'b00;
        bus.safe_point_i   = 1'b0; bus.mret_i  = 1'b0;
        bus_s.mstatus_mie_i = 1'b0; bus_s.mip_i = 2'b00; bus_s.mie_i = 2'b00;
        bus_s.safe_point_i  = 1'b0; bus_s.mret_i = 1'b0;
        #3;
        check_main("reset", 1'b0, '0, 2'b00, 1'b0, 0);
        tick();
        reset_i = 1'b0;
        tick();
        check_main("idle_after_reset", 1'b0, '0, 2'b00, 1'b0, 0);

        // 1: remote only, safe point already high -> pulse two cycles after take
        bus.mie_i = 2'b01; bus.mstatus_mie_i = 1'b1; bus.safe_point_i = 1'b1;
        tick();
        check_main("t1_no_pend", 1'b0, '0, 2'b00, 1'b0, 0);
        bus.mip_i = 2'b01;
        tick();
        check_main("t1_arm", 1'b0, '0, 2'b01, 1'b0, 0);
        tick();
        check_main("t1_enter", 1'b1, 22'h1, 2'b01, 1'b0, 0);
        tick();
        exp_count = 1;
        check_main("t1_handler", 1'b0, '0, 2'b01, 1'b1, exp_count);

        // 5: pending held (and trace raised) in HANDLER -> no nesting
        bus.mie_i = 2'b11; bus.mip_i = 2'b11;
        tick();
        check_main("t5_hold1", 1'b0, '0, 2'b01, 1'b1, exp_count);
        tick();
        check_main("t5_hold2", 1'b0, '0, 2'b01, 1'b1, exp_count);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        check_main("t5_mret_idle", 1'b0, '0, 2'b00, 1'b0, exp_count);
        tick();
        check_main("t5_rearm", 1'b0, '0, 2'b01, 1'b0, exp_count);
        tick();
        check_main("t5_reenter", 1'b1, 22'h1, 2'b01, 1'b0, exp_count);
        bus.mip_i = 2'b00;
        tick();
        exp_count = 2;
        check_main("t5_handler", 1'b0, '0, 2'b01, 1'b1, exp_count);
        bus.mret_i = 1'b1;
        tick();
        bus.mret_i = 1'b0;
        check_main("t5_exit", 1'b0, '0, 2'b00, 1'b0, exp_count);

        // 2: both pending, no safe point for five cycles -> waits in ARM on remote
        bus.safe_point_i = 1'b0; bus.mip_i = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_main($sformatf("t2_arm%0d", i), 1'b0, '0, 2'b01, 1'b0, exp_count);
        end
        bus.safe_point_i = 1'b1;
        tick();
        check_main("t2_enter", 1'b1, 22'h1, 2'b01, 1'b0, exp_count);
        tick();
        exp_count = 3;
        check_main("t2_handler", 1'b0, '0, 2'b01, 1'b1, exp_count);
        bus.mret_i = 1'b1; bus.mip_i = 2'b00;
        tick();
        bus.mret_i = 1'b0;

        // 3: trace latched in ARM, then remote preempts it
        bus.safe_point_i = 1'b0; bus.mip_i = 2'b10;
        tick();
        check_main("t3_arm_trace", 1'b0, '0, 2'b10, 1'b0, exp_count);
        tick();
        check_main("t3_arm_trace2", 1'b0, '0, 2'b10, 1'b0, exp_count);
        bus.mip_i = 2'b11;
        tick();
        check_main("t3_preempt", 1'b0, '0, 2'b01, 1'b0, exp_count);
        bus.safe_point_i = 1'b1;
        tick();
        check_main("t3_enter", 1'b1, 22'h1, 2'b01, 1'b0, exp_count);
        tick();
        exp_count = 4;
        check_main("t3_handler", 1'b0, '0, 2'b01, 1'b1, exp_count);
        bus.mret_i = 1'b1; bus.mip_i = 2'b00;
        tick();
        bus.mret_i = 1'b0;

        // Trace alone takes the trace vector
        bus.mip_i = 2'b10;
        tick();
        check_main("tr_arm", 1'b0, '0, 2'b10, 1'b0, exp_count);
        tick();
        check_main("tr_enter", 1'b1, 22'h2, 2'b10, 1'b0, exp_count);
        tick();
        exp_count = 5;
        check_main("tr_handler", 1'b0, '0, 2'b10, 1'b1, exp_count);
        bus.mret_i = 1'b1; bus.mip_i = 2'b00;
        tick();
        bus.mret_i = 1'b0;

        // 4: abort from ARM by dropping the cause, then by dropping mstatus.mie
        bus.mie_i = 2'b01; bus.safe_point_i = 1'b0; bus.mip_i = 2'b01;
        tick();
        check_main("t4_arm_a", 1'b0, '0, 2'b01, 1'b0, exp_count);
        bus.mip_i = 2'b00;
        tick();
        check_main("t4_abort_mip", 1'b0, '0, 2'b00, 1'b0, exp_count);
        tick();
        check_main("t4_idle_a", 1'b0, '0, 2'b00, 1'b0, exp_count);
        bus.mip_i = 2'b01;
        tick();
        check_main("t4_arm_b", 1'b0, '0, 2'b01, 1'b0, exp_count);
        bus.mstatus_mie_i = 1'b0;
        tick();
        check_main("t4_abort_mie", 1'b0, '0, 2'b00, 1'b0, exp_count);
        tick();
        check_main("t4_idle_b", 1'b0, '0, 2'b00, 1'b0, exp_count);

        // mret outside HANDLER is ignored
        bus.mstatus_mie_i = 1'b1;
        tick();
        check_main("mret_arm_pre", 1'b0, '0, 2'b01, 1'b0, exp_count);
        bus.mret_i = 1'b1;
        tick();
        check_main("mret_arm_ignored", 1'b0, '0, 2'b01, 1'b0, exp_count);
        bus.mret_i = 1'b0; bus.mip_i = 2'b00;
        tick();
        check_main("mret_arm_exit", 1'b0, '0, 2'b00, 1'b0, exp_count);

        // 6: 2-bit counter saturates at 3
        bus_s.mstatus_mie_i = 1'b1; bus_s.mie_i = 2'b01;
        bus_s.safe_point_i  = 1'b1; bus_s.mip_i = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tick();
            tick();
            check($sformatf("t6_pulse%0d", i), 32'(bus_s.interrupt_entered_o), 32'd1);
            tick();
            check($sformatf("t6_count%0d", i), 32'(bus_s.interrupt_count_o), 32'(exp_s[i]));
            bus_s.mret_i = 1'b1;
            tick();
            bus_s.mret_i = 1'b0;
        end

        // Async reset in the middle of ARM clears outputs before any clock edge
        bus_s.safe_point_i = 1'b0;
        tick();
        check("t6_arm_cause", 32'(bus_s.interrupt_cause_o), 32'h1);
        #2;
        reset_i = 1'b1;
        #1;
        check("t6_rst_cause",   32'(bus_s.interrupt_cause_o),   32'h0);
        check("t6_rst_count",   32'(bus_s.interrupt_count_o),   32'h0);
        check("t6_rst_entered", 32'(bus_s.interrupt_entered_o), 32'h0);
        check("t6_rst_handler", 32'(bus_s.in_handler_o),        32'h0);
        check("t6_rst_main_cnt", 32'(bus.interrupt_count_o),    32'h0);
        tick();
        reset_i = 1'b0;
        bus_s.mip_i = 2'b00;
        tick();
        check("t6_post_rst_cause", 32'(bus_s.interrupt_cause_o), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
